// File: rtl/edram_bank.sv
// edram_bank: tile-level eDRAM storage model with per-word consumer counters.
// Serves one request at a time with a fixed request-to-done latency. A read hands
// out the stored word and consumes one unit of its counter. A write may only
// replace a word whose counter has drained to zero.
module edram_bank #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 4,
    parameter int EDRAM_SIZE = 32,
    parameter int MEM_LAT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ram_ren,
    input  logic                  ram_wen,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_busy,
    output logic                  ram_done,
    output logic [1:0]            ram_status,
    output logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int IDX_W = (EDRAM_SIZE > 1) ? $clog2(EDRAM_SIZE) : 1;
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_INVALID = 2'b01;
    localparam logic [1:0] ST_REJECT  = 2'b10;
    localparam logic [1:0] ST_RANGE   = 2'b11;

    typedef enum logic {FREE, BUSY} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [LAT_W-1:0]      r_lat;
    logic [LAT_W-1:0]      w_latNext;
    logic                  w_doneNext;

    logic [DATA_WIDTH-1:0] r_mem [EDRAM_SIZE];

    logic                  r_done;
    logic [1:0]            r_status;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_pendStatus;
    logic [DATA_WIDTH-1:0] r_pendRdata;

    logic                  w_accept;
    logic                  w_inRange;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_word;
    logic [CNT_WIDTH-1:0]  w_wordCnt;
    logic [1:0]            w_respStatus;
    logic [DATA_WIDTH-1:0] w_respRdata;
    logic                  w_memWe;
    logic [DATA_WIDTH-1:0] w_memWdata;
    logic [1:0]            w_outStatus;
    logic [DATA_WIDTH-1:0] w_outRdata;

    assign w_accept  = (r_state == FREE) && (ram_ren || ram_wen);
    assign w_inRange = ram_addr < ADDR_WIDTH'(EDRAM_SIZE);
    assign w_idx     = ram_addr[IDX_W-1:0];
    assign w_word    = r_mem[w_idx];
    assign w_wordCnt = w_word[DATA_WIDTH-1 -: CNT_WIDTH];

    // Decide the response and the array update for the request on the inputs this cycle.
    always_comb begin
        w_respStatus = ST_OK;
        w_respRdata  = '0;
        w_memWe      = 1'b0;
        w_memWdata   = w_word;
        if (!w_inRange) begin
            w_respStatus = ST_RANGE;
        end else if (ram_ren) begin
            if (w_wordCnt == '0) begin
                w_respStatus = ST_INVALID;
            end else begin
                w_respRdata = w_word;
                w_memWe     = 1'b1;
                w_memWdata  = {w_wordCnt - CNT_WIDTH'(1), w_word[DATA_WIDTH-CNT_WIDTH-1:0]};
            end
        end else begin
            if (w_wordCnt == '0) begin
                w_memWe    = 1'b1;
                w_memWdata = ram_data;
            end else begin
                w_respStatus = ST_REJECT;
            end
        end
    end

    // Next-state logic: count the latency down while busy and raise done as it expires.
    always_comb begin
        w_nextState = r_state;
        w_latNext   = r_lat;
        w_doneNext  = 1'b0;
        case (r_state)
            FREE: begin
                if (w_accept) begin
                    if (MEM_LAT == 1) begin
                        w_doneNext = 1'b1;
                    end else begin
                        w_nextState = BUSY;
                        w_latNext   = LAT_W'(MEM_LAT - 1);
                    end
                end
            end
            BUSY: begin
                if (r_lat == LAT_W'(1)) begin
                    w_nextState = FREE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_latNext = r_lat - LAT_W'(1);
                end
            end
            default: w_nextState = FREE;
        endcase
    end

    // The response comes straight from the current request only when the latency is a single cycle.
    assign w_outStatus = (r_state == FREE) ? w_respStatus : r_pendStatus;
    assign w_outRdata  = (r_state == FREE) ? w_respRdata  : r_pendRdata;

    // State and latency counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FREE;
            r_lat   <= '0;
        end else begin
            r_state <= w_nextState;
            r_lat   <= w_latNext;
        end
    end

    // Storage array: the read-modify-write happens at the accept edge, and reset clears every word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < EDRAM_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && w_memWe) begin
            r_mem[w_idx] <= w_memWdata;
        end
    end

    // Hold the pending response during the latency, then present it with the done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pendStatus <= ST_OK;
            r_pendRdata  <= '0;
            r_done       <= 1'b0;
            r_status     <= ST_OK;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_pendStatus <= w_respStatus;
                r_pendRdata  <= w_respRdata;
            end
            r_done <= w_doneNext;
            if (w_doneNext) begin
                r_status <= w_outStatus;
                r_rdata  <= w_outRdata;
            end
        end
    end

    assign ram_busy   = (r_state == BUSY);
    assign ram_done   = r_done;
    assign ram_status = r_status;
    assign ram_rdata  = r_rdata;

endmodule
